sweep_stats: RTL and testbench
==============================

# sweep_stats

Downstream consumer of the address-indexed lookup array. Takes the fixed-point sample stream the array produces as its address counter sweeps 0..2^ADDR_BITS-1. For each complete, in-order sweep it computes sum, min, max and mean. Each result is presented on a registered valid/ready output for probing or later stages.

## Interface
- DATA_WIDTH, 18: width of signed fixed-point input sample. Exponent is implicit and shared by data, min, max, mean and sum.
- ADDR_BITS, 2: address width; sweep length N = 2^ADDR_BITS.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-low. Asserted at 0; release is synchronised externally.
- in_valid  in  1  addr/data pair is valid this cycle.
- addr  in  ADDR_BITS  array address the sample belongs to.
- data  in  DATA_WIDTH  signed sample.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts result.
- sum  out  DATA_WIDTH+ADDR_BITS  signed sweep sum.
- min, max  out  DATA_WIDTH  signed sweep extremes.
- mean  out  DATA_WIDTH  sum >>> ADDR_BITS (arithmetic, floor).
- seq_err  out  1  sticky; set on out-of-order address, cleared only by reset.
- overrun  out  8  saturating count of results dropped due to backpressure.

## Operation
- FSM states: SYNC (wait for sweep start) and ACCUM.
- SYNC: a valid sample with addr==0 loads acc_sum=data, acc_min=acc_max=data, and sets exp_addr=1.
  - If N==1, the sweep completes immediately.
  - Otherwise go to ACCUM.
  - Valid samples with addr!=0 are ignored and do not set seq_err.
- ACCUM, valid sample with addr==exp_addr:
  - Accumulate sum with a sign-extended add; no overflow is possible at this width.
  - Update min/max using signed compare.
  - Increment exp_addr.
  - If addr==N-1, the sweep completes and the FSM returns to SYNC.
- ACCUM, valid sample with addr!=exp_addr:
  - Set seq_err and discard the sweep.
  - If addr==0, restart the sweep with this sample and stay in ACCUM.
  - Otherwise go to SYNC.
- in_valid low: no state change. Gaps inside a sweep are allowed.
- Completion loads the result register (sum, min, max, mean) and sets out_valid, unless the register is occupied and not being consumed this cycle.
  - In that case the new result is dropped, the old result is held, and overrun increments, saturating at 255.
- Output handshake: a transfer occurs when out_valid && out_ready. out_valid clears after a transfer unless a new result loads in the same cycle.
- Outputs are stable while out_valid && !out_ready.

## Timing
- Reset values:
  - FSM=SYNC, exp_addr=0, accumulators=0.
  - out_valid=0, sum=min=max=mean=0, seq_err=0, overrun=0.
- Latency: a result is visible with out_valid=1 one cycle after the clock edge that accepts the addr==N-1 sample.
- Throughput: one sample per cycle. Back-to-back sweeps with no gap (addr N-1 then 0) are accepted with no lost sample.
- Simultaneous completion and transfer of the old result: the new result loads and out_valid stays 1. No overrun.
- Reset assertion mid-sweep or mid-handshake clears everything immediately, asynchronously. The partial sweep is lost.
- mean is registered together with sum, not derived combinationally at the output.

## Structure
- Package sweep_stats_pkg holds:
  - the FSM state enum (SYNC, ACCUM);
  - the sum-width helper function (DATA_WIDTH+ADDR_BITS);
  - the overrun width constant (8).
- Sub-module sweep_stats_acc: datapath containing the sum/min/max accumulators with load/accumulate controls.
- Top level holds the FSM, the address check, the result register, the handshake, and the error/overrun logic.

## Test plan
All scenarios use ADDR_BITS=2 and DATA_WIDTH=16.
- Nominal sweep: addr 0..3, data 10, 20, -5, 7, out_ready=1. Expect one cycle later sum=32, min=-5, max=20, mean=8, out_valid for 1 cycle.
- Negative floor: data -1, -2, -1, -1. Expect sum=-5, mean=-2, min=-2, max=-1.
- Sequence error: addr 0, 1, 3. Expect seq_err=1, no result. A following sweep 0..3 produces a correct result, and seq_err stays 1.
- Backpressure: out_ready=0 across two complete sweeps. Expect the first result held and overrun=1. Then out_ready=1 for one cycle: transfer, then out_valid=0.
- Simultaneous: out_valid=1 and out_ready asserted in the same cycle as a completion. Expect new values loaded, out_valid=1, overrun unchanged.
- Reset mid-sweep: after addr 0, 1, assert rst=0 for 1 cycle. Expect all outputs 0. A subsequent sweep starting at addr 2 is ignored until addr 0.

Source files
------------

// File: rtl/sweep_stats_pkg.sv
// Shared types and constants for the sweep statistics block.
package sweep_stats_pkg;

   // FSM state encoding
   typedef logic [0:0] state_t;
   localparam state_t StSync  = 1'b0;
   localparam state_t StAccum = 1'b1;

   localparam int unsigned OverrunWidth = 8;

   // A sum of 2^addr_bits samples needs addr_bits extra bits of headroom.
   function automatic int unsigned sum_width(input int unsigned data_width,
                                             input int unsigned addr_bits);
      return data_width + addr_bits;
   endfunction

endpackage

// File: rtl/sweep_stats_acc.sv
// Sum/min/max accumulators. The *_nxt outputs show the values after this cycle's update,
// so the final sample of a sweep can be captured without an extra cycle.
module sweep_stats_acc
   import sweep_stats_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 18,
   parameter int unsigned ADDR_BITS  = 2
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic                                          load_i,
   input  logic                                          acc_i,
   input  logic [DATA_WIDTH-1:0]                         data_i,
   output logic [sum_width(DATA_WIDTH, ADDR_BITS)-1:0]   sum_nxt_o,
   output logic [DATA_WIDTH-1:0]                         min_nxt_o,
   output logic [DATA_WIDTH-1:0]                         max_nxt_o
);

   localparam int unsigned SumW = sum_width(DATA_WIDTH, ADDR_BITS);

   logic [SumW-1:0]       sum_q, sum_d, data_ext;
   logic [DATA_WIDTH-1:0] min_q, min_d, max_q, max_d;

   assign data_ext = {{ADDR_BITS{data_i[DATA_WIDTH-1]}}, data_i};

   always_comb begin
      sum_d = sum_q;
      min_d = min_q;
      max_d = max_q;
      if (load_i) begin
         sum_d = data_ext;
         min_d = data_i;
         max_d = data_i;
      end else if (acc_i) begin
         sum_d = sum_q + data_ext;
         if ($signed(data_i) < $signed(min_q)) min_d = data_i;
         if ($signed(data_i) > $signed(max_q)) max_d = data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q <= '0;
         min_q <= '0;
         max_q <= '0;
      end else begin
         sum_q <= sum_d;
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign sum_nxt_o = sum_d;
   assign min_nxt_o = min_d;
   assign max_nxt_o = max_d;

endmodule

// File: rtl/sweep_stats.sv
// Per-sweep sum/min/max/mean over an in-order address sweep 0..2^ADDR_BITS-1, with a
// registered valid/ready result, sticky sequence error and saturating overrun count.
module sweep_stats
   import sweep_stats_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 18,
   parameter int unsigned ADDR_BITS  = 2   // must be >= 1
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic                                          in_valid_i,
   input  logic [ADDR_BITS-1:0]                          addr_i,
   input  logic [DATA_WIDTH-1:0]                         data_i,
   output logic                                          out_valid_o,
   input  logic                                          out_ready_i,
   output logic [sum_width(DATA_WIDTH, ADDR_BITS)-1:0]   sum_o,
   output logic [DATA_WIDTH-1:0]                         min_o,
   output logic [DATA_WIDTH-1:0]                         max_o,
   output logic [DATA_WIDTH-1:0]                         mean_o,
   output logic                                          seq_err_o,
   output logic [OverrunWidth-1:0]                       overrun_o
);

   localparam int unsigned SumW = sum_width(DATA_WIDTH, ADDR_BITS);
   localparam logic [ADDR_BITS-1:0] LastAddr = '1;

   state_t                  state_q, state_d;
   logic [ADDR_BITS-1:0]    exp_q, exp_d;
   logic                    load, acc, done, err_set;
   logic [SumW-1:0]         sum_nxt, sum_q, sum_d;
   logic [DATA_WIDTH-1:0]   min_nxt, max_nxt, min_q, min_d, max_q, max_d, mean_q, mean_d;
   logic                    valid_q, valid_d, seq_err_q, seq_err_d;
   logic [OverrunWidth-1:0] overrun_q, overrun_d;

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      load    = 1'b0;
      acc     = 1'b0;
      done    = 1'b0;
      err_set = 1'b0;
      if (in_valid_i) begin
         case (state_q)
            StSync: begin
               if (addr_i == '0) begin
                  load    = 1'b1;
                  exp_d   = ADDR_BITS'(1);
                  state_d = StAccum;
               end
            end
            default: begin
               if (addr_i == exp_q) begin
                  acc   = 1'b1;
                  exp_d = exp_q + ADDR_BITS'(1);
                  if (addr_i == LastAddr) begin
                     done    = 1'b1;
                     state_d = StSync;
                  end
               end else begin
                  err_set = 1'b1;
                  // An unexpected addr 0 is a fresh sweep start, so keep it.
                  if (addr_i == '0) begin
                     load  = 1'b1;
                     exp_d = ADDR_BITS'(1);
                  end else begin
                     exp_d   = '0;
                     state_d = StSync;
                  end
               end
            end
         endcase
      end
   end

   sweep_stats_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_acc (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (load),
      .acc_i     (acc),
      .data_i    (data_i),
      .sum_nxt_o (sum_nxt),
      .min_nxt_o (min_nxt),
      .max_nxt_o (max_nxt)
   );

   always_comb begin
      valid_d   = valid_q;
      sum_d     = sum_q;
      min_d     = min_q;
      max_d     = max_q;
      mean_d    = mean_q;
      overrun_d = overrun_q;
      seq_err_d = seq_err_q | err_set;
      if (valid_q && out_ready_i) valid_d = 1'b0;
      if (done) begin
         if (!valid_q || out_ready_i) begin
            valid_d = 1'b1;
            sum_d   = sum_nxt;
            min_d   = min_nxt;
            max_d   = max_nxt;
            // Arithmetic shift by ADDR_BITS is exactly this bit slice.
            mean_d  = sum_nxt[ADDR_BITS +: DATA_WIDTH];
         end else if (overrun_q != '1) begin
            overrun_d = overrun_q + OverrunWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StSync;
         exp_q     <= '0;
         valid_q   <= 1'b0;
         sum_q     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         mean_q    <= '0;
         seq_err_q <= 1'b0;
         overrun_q <= '0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         valid_q   <= valid_d;
         sum_q     <= sum_d;
         min_q     <= min_d;
         max_q     <= max_d;
         mean_q    <= mean_d;
         seq_err_q <= seq_err_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_valid_o = valid_q;
   assign sum_o       = sum_q;
   assign min_o       = min_q;
   assign max_o       = max_q;
   assign mean_o      = mean_q;
   assign seq_err_o   = seq_err_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sweep_stats.sv
// Directed bench for sweep_stats: table of nominal sweeps plus hand-written corner sequences.
module tb_sweep_stats;

   localparam int unsigned DW = 16;
   localparam int unsigned AB = 2;
   localparam int unsigned SW = DW + AB;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic [AB-1:0]        addr = '0;
   logic signed [DW-1:0] data = '0;
   logic                 out_ready = 1'b1;
   logic                 out_valid;
   logic signed [SW-1:0] sum;
   logic signed [DW-1:0] min_v, max_v, mean;
   logic                 seq_err;
   logic [7:0]           overrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sweep_stats #(
      .DATA_WIDTH (DW),
      .ADDR_BITS  (AB)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .addr_i      (addr),
      .data_i      (data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sum_o       (sum),
      .min_o       (min_v),
      .max_o       (max_v),
      .mean_o      (mean),
      .seq_err_o   (seq_err),
      .overrun_o   (overrun)
   );

   typedef struct {
      logic signed [DW-1:0] d [4];
      logic signed [SW-1:0] e_sum;
      logic signed [DW-1:0] e_min;
      logic signed [DW-1:0] e_max;
      logic signed [DW-1:0] e_mean;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [AB-1:0] a, input logic signed [DW-1:0] d);
      in_valid = 1'b1;
      addr     = a;
      data     = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic sweep4(input int d0, input int d1, input int d2, input int d3);
      send(2'd0, DW'(d0));
      send(2'd1, DW'(d1));
      send(2'd2, DW'(d2));
      send(2'd3, DW'(d3));
   endtask

   task automatic chk_res(input string tag, input int s, input int mn, input int mx,
                          input int mu);
      chk({tag, ".valid"}, int'(out_valid), 1);
      chk({tag, ".sum"}, int'(sum), s);
      chk({tag, ".min"}, int'(min_v), mn);
      chk({tag, ".max"}, int'(max_v), mx);
      chk({tag, ".mean"}, int'(mean), mu);
   endtask

   initial begin
      vecs[0] = '{d: '{16'sd10, 16'sd20, -16'sd5, 16'sd7},
                  e_sum: 32, e_min: -5, e_max: 20, e_mean: 8};
      vecs[1] = '{d: '{-16'sd1, -16'sd2, -16'sd1, -16'sd1},
                  e_sum: -5, e_min: -2, e_max: -1, e_mean: -2};
      vecs[2] = '{d: '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767},
                  e_sum: 131068, e_min: 32767, e_max: 32767, e_mean: 32767};
      vecs[3] = '{d: '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768},
                  e_sum: -131072, e_min: -32768, e_max: -32768, e_mean: -32768};
      vecs[4] = '{d: '{16'sd0, 16'sd0, 16'sd0, 16'sd1},
                  e_sum: 1, e_min: 0, e_max: 1, e_mean: 0};
      vecs[5] = '{d: '{16'sd5, -16'sd3, 16'sd100, -16'sd100},
                  e_sum: 2, e_min: -100, e_max: 100, e_mean: 0};
      vecs[6] = '{d: '{-16'sd7, 16'sd0, 16'sd0, 16'sd0},
                  e_sum: -7, e_min: -7, e_max: 0, e_mean: -2};

      // Reset state
      tick();
      tick();
      chk("rst.valid", int'(out_valid), 0);
      chk("rst.sum", int'(sum), 0);
      chk("rst.min", int'(min_v), 0);
      chk("rst.max", int'(max_v), 0);
      chk("rst.mean", int'(mean), 0);
      chk("rst.seq_err", int'(seq_err), 0);
      chk("rst.overrun", int'(overrun), 0);
      rst_n = 1'b1;
      tick();

      // Nominal sweeps from the table
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         for (int k = 0; k < 4; k++) send(AB'(k), vecs[i].d[k]);
         chk_res($sformatf("vec%0d", i), int'(vecs[i].e_sum), int'(vecs[i].e_min),
                 int'(vecs[i].e_max), int'(vecs[i].e_mean));
         tick();
         chk($sformatf("vec%0d.valid_clear", i), int'(out_valid), 0);
      end
      chk("nom.seq_err", int'(seq_err), 0);
      chk("nom.overrun", int'(overrun), 0);

      // Sequence error: 0,1,3 then a good sweep with an idle gap
      send(2'd0, 16'sd9);
      send(2'd1, 16'sd9);
      send(2'd3, 16'sd9);
      chk("seq.err_set", int'(seq_err), 1);
      chk("seq.no_result", int'(out_valid), 0);
      send(2'd0, 16'sd1);
      send(2'd1, 16'sd2);
      tick();
      send(2'd2, 16'sd3);
      send(2'd3, 16'sd4);
      chk_res("seq.after", 10, 1, 4, 2);
      chk("seq.err_sticky", int'(seq_err), 1);
      tick();

      // Backpressure: two back-to-back sweeps with no consumer
      out_ready = 1'b0;
      sweep4(1, 1, 1, 1);
      chk_res("bp.first", 4, 1, 1, 1);
      sweep4(2, 2, 2, 2);
      chk_res("bp.held", 4, 1, 1, 1);
      chk("bp.overrun", int'(overrun), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp.xfer_clear", int'(out_valid), 0);
      chk("bp.overrun_keep", int'(overrun), 1);

      // Completion in the same cycle as the old result is consumed
      sweep4(3, 3, 3, 3);
      chk_res("sim.old", 12, 3, 3, 3);
      send(2'd0, 16'sd4);
      send(2'd1, 16'sd4);
      send(2'd2, 16'sd4);
      chk("sim.still_old", int'(sum), 12);
      out_ready = 1'b1;
      send(2'd3, -16'sd4);
      chk_res("sim.new", 8, -4, 4, 2);
      chk("sim.overrun", int'(overrun), 1);
      tick();
      chk("sim.valid_clear", int'(out_valid), 0);

      // Asynchronous reset mid-sweep, with a result pending
      out_ready = 1'b0;
      sweep4(6, 6, 6, 6);
      send(2'd0, 16'sd9);
      send(2'd1, 16'sd9);
      chk("rmid.pre_valid", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("rmid.valid", int'(out_valid), 0);
      chk("rmid.sum", int'(sum), 0);
      chk("rmid.min", int'(min_v), 0);
      chk("rmid.max", int'(max_v), 0);
      chk("rmid.mean", int'(mean), 0);
      chk("rmid.seq_err", int'(seq_err), 0);
      chk("rmid.overrun", int'(overrun), 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      send(2'd2, 16'sd50);
      send(2'd3, 16'sd50);
      chk("rmid.ignored", int'(out_valid), 0);
      chk("rmid.no_err", int'(seq_err), 0);
      sweep4(2, 4, 6, 8);
      chk_res("rmid.after", 20, 2, 8, 5);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
